// File: rtl/perceptron_neuron_10i_if.sv
// perceptron_neuron_10i_if: start/operand/result bundle between the upstream converter and the neuron
interface perceptron_neuron_10i_if #(parameter int DATA_W = 32);
  logic                     i_start;
  logic signed [DATA_W-1:0] i_in [10];
  logic signed [DATA_W-1:0] i_w [10];
  logic signed [DATA_W-1:0] i_bias;
  logic signed [DATA_W-1:0] o_out;
  logic                     o_done;
  logic                     o_busy;
  modport master(output i_start, i_in, i_w, i_bias, input o_out, o_done, o_busy);
  modport slave(input i_start, i_in, i_w, i_bias, output o_out, o_done, o_busy);
endinterface

// File: rtl/perceptron_neuron_10i.sv
// perceptron_neuron_10i: ten-term fixed-point MAC + bias, one term per clock, saturated output.
// Define RELU_EN to clamp negative results to zero after saturation.
module perceptron_neuron_10i #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 52
) (
  input logic clk,
  input logic rst_n,
  perceptron_neuron_10i_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2;
  logic [1:0]                 r_state;
  logic [3:0]                 r_idx;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [DATA_W-1:0]   r_x [10];
  logic signed [DATA_W-1:0]   r_w [10];
  logic signed [DATA_W-1:0]   r_out;
  logic                       r_done, r_busy;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_term;
  logic [ACC_W-DATA_W:0]      w_hi;
  logic                       w_ovf, w_accept;
  logic signed [DATA_W-1:0]   w_sat, w_act;
  always_comb begin
    w_accept = r_state == S_IDLE && bus.i_start;
    w_prod   = (2*DATA_W)'(r_x[r_idx]) * (2*DATA_W)'(r_w[r_idx]);
    w_term   = ACC_W'(w_prod >>> FRAC_W);
    // accumulator fits DATA_W only when all bits above the sign bit agree with it
    w_hi     = r_acc[ACC_W-1:DATA_W-1];
    w_ovf    = !(&w_hi) && |w_hi;
    w_sat    = !w_ovf ? r_acc[DATA_W-1:0]
             : r_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`ifdef RELU_EN
    w_act    = w_sat[DATA_W-1] ? '0 : w_sat;
`else
    w_act    = w_sat;
`endif
  end
  always_ff @(posedge clk)
    if (w_accept) begin
      r_x <= bus.i_in;
      r_w <= bus.i_w;
    end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_acc   <= '0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_acc   <= ACC_W'(bus.i_bias);
        r_idx   <= '0;
        r_busy  <= 1'b1;
        r_state <= S_MAC;
      end else if (r_state == S_MAC) begin
        r_acc   <= r_acc + w_term;
        r_idx   <= r_idx + 4'd1;
        r_state <= r_idx == 4'd9 ? S_OUT : S_MAC;
      end else if (r_state == S_OUT) begin
        r_out   <= w_act;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= S_IDLE;
      end
    end
  end
  assign bus.o_out  = r_out;
  assign bus.o_done = r_done;
  assign bus.o_busy = r_busy;
endmodule

// File: tb/tb_perceptron_neuron_10i.sv
// tb_perceptron_neuron_10i: directed vectors with hand-computed results for the ten-term neuron
module tb_perceptron_neuron_10i;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  perceptron_neuron_10i_if #(.DATA_W(32)) bus();
  perceptron_neuron_10i dut(.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef RELU_EN
  localparam logic RELU = 1'b1;
`else
  localparam logic RELU = 1'b0;
`endif
  int n_run = 0;
  int n_fail = 0;
  function automatic logic [31:0] act(input logic [31:0] v);
    return (RELU && v[31]) ? 32'h0 : v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [31:0] x, input logic [31:0] w, input logic [31:0] b);
    for (int i = 0; i < 10; i++) begin
      bus.i_in[i] = x;
      bus.i_w[i]  = w;
    end
    bus.i_bias = b;
  endtask
  task automatic load_mix();
    load(32'h0, 32'h0, 32'h0001_0000);
    bus.i_in[0] = 32'h0003_0000; bus.i_w[0] = 32'hFFFF_C000;
    bus.i_in[5] = 32'h0001_8000; bus.i_w[5] = 32'h0002_0000;
    bus.i_in[9] = 32'h0002_0000; bus.i_w[9] = 32'h0002_0000;
  endtask
  task automatic pulse();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.o_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic run(input string tag, input logic [31:0] exp);
    int cyc;
    pulse();
    chk({tag, " busy"}, bus.o_busy, 1);
    wait_done(cyc);
    chk({tag, " latency"}, cyc, 11);
    chk({tag, " out"}, bus.o_out, exp);
    chk({tag, " busy@done"}, bus.o_busy, 0);
    @(negedge clk);
    chk({tag, " done width"}, bus.o_done, 0);
  endtask
  initial begin
    int cyc, nd;
    logic [31:0] o1;
    bus.i_start = 1'b0;
    load(32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst out", bus.o_out, 0);
    chk("rst done", bus.o_done, 0);
    chk("rst busy", bus.o_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    load(32'h0001_0000, 32'h0000_8000, 32'h0);
    run("t1", 32'h0005_0000);
    load(32'h0, 32'h0, 32'h0000_8000);
    bus.i_in[0] = 32'hFFFE_0000; bus.i_w[0] = 32'h0001_0000;
    run("t2", act(32'hFFFE_8000));
    load(32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
    run("t3 pos sat", 32'h7FFF_FFFF);
    load(32'h7FFF_0000, 32'h8001_0000, 32'h0);
    run("t3 neg sat", act(32'h8000_0000));
    load(32'h0, 32'h0, 32'h0);
    bus.i_in[0] = 32'hFFFF_FFFF; bus.i_w[0] = 32'h0000_8000;
    run("t4 floor", act(32'hFFFF_FFFF));
    load_mix();
    run("mix", 32'h0007_4000);
    // restart while busy must be ignored, operands already captured
    load(32'h0001_0000, 32'h0000_8000, 32'h0);
    pulse();
    load_mix();
    repeat (4) @(negedge clk);
    pulse();
    nd = 0;
    o1 = '0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_done) begin
        nd++;
        o1 = bus.o_out;
      end
    end
    chk("t5 done count", nd, 1);
    chk("t5 out", o1, 32'h0005_0000);
    load(32'h0001_0000, 32'h0000_8000, 32'h0);
    pulse();
    wait_done(cyc);
    chk("t5 first latency", cyc, 11);
    load_mix();
    pulse();
    wait_done(cyc);
    chk("t5 b2b gap", cyc + 1, 12);
    chk("t5 b2b out", bus.o_out, 32'h0007_4000);
    @(negedge clk);
    load(32'h0001_0000, 32'h0000_8000, 32'h0);
    pulse();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6 out", bus.o_out, 0);
    chk("t6 done", bus.o_done, 0);
    chk("t6 busy", bus.o_busy, 0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_done) nd++;
    end
    chk("t6 no done", nd, 0);
    run("t6 restart", 32'h0005_0000);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
